// File: rtl/ram_window_rd.sv
// Windowed RAM reader: random-access writes, NOUT consecutive words (wrapping mod DEPTH) read per request.
// Read latency 1 cycle; window held until dout_ack. Optional RAM_WINDOW_BYPASS_EN forwards same-edge writes into dout.
module ram_window_rd #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 9,
  parameter int DEPTH  = 512,
  parameter int NOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wren,
  input  logic [AWIDTH-1:0]      waddr,
  input  logic [DWIDTH-1:0]      din,
  input  logic                   rd_req,
  input  logic [AWIDTH-1:0]      raddr,
  output logic                   rd_ready,
  output logic [NOUT*DWIDTH-1:0] dout,
  output logic                   dout_valid,
  input  logic                   dout_ack,
  output logic                   wr_err
);

  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);

  logic [DWIDTH-1:0]      mem_q [0:DEPTH-1];

  logic [NOUT*DWIDTH-1:0] dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   wr_err_q, wr_err_d;
  logic                   init_q, init_d;

  logic                   wr_ok;
  logic                   wr_bad;
  logic                   accept;
  logic [AWIDTH:0]        base;
  logic [AWIDTH:0]        word_addr;
  logic [DWIDTH-1:0]      word_dat;
  logic [NOUT*DWIDTH-1:0] window;

  assign wr_ok    = wren && ({1'b0, waddr} < DEPTH_W);
  assign wr_bad   = wren && ({1'b0, waddr} >= DEPTH_W);
  assign rd_ready = !dout_valid_q || dout_ack;
  // init_q blocks the edge on which reset is released
  assign accept   = rd_req && rd_ready && init_q;

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign wr_err     = wr_err_q;

  // base < DEPTH and k < DEPTH, so one conditional subtract completes the wrap
  always_comb begin
    base      = {1'b0, raddr} % DEPTH_W;
    word_addr = '0;
    word_dat  = '0;
    window    = '0;
    for (int k = 0; k < NOUT; k++) begin
      word_addr = base + (AWIDTH+1)'(k);
      if (word_addr >= DEPTH_W) begin
        word_addr = word_addr - DEPTH_W;
      end
      word_dat = mem_q[word_addr[AWIDTH-1:0]];
`ifdef RAM_WINDOW_BYPASS_EN
      if (wr_ok && (word_addr[AWIDTH-1:0] == waddr)) begin
        word_dat = din;
      end
`endif
      window[k*DWIDTH +: DWIDTH] = word_dat;
    end
  end

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    wr_err_d     = wr_err_q | wr_bad;
    init_d       = 1'b1;
    if (accept) begin
      dout_d       = window;
      dout_valid_d = 1'b1;
    end else if (dout_ack) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      wr_err_q     <= 1'b0;
      init_q       <= 1'b0;
    end else begin
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      wr_err_q     <= wr_err_d;
      init_q       <= init_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[waddr] <= din;
    end
  end

endmodule
